// File: rtl/usb_pkg.sv
// Shared USB definitions: PID encodings, receive FSM states, error codes and
// the serial CRC5 step used by both token receive and transmit paths.
package usb_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SOF   = 4'b0101,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_DATA2 = 4'b0111,
    PID_MDATA = 4'b1111,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110,
    PID_NYET  = 4'b0110,
    PID_PRE   = 4'b1100,
    PID_SPLIT = 4'b1000,
    PID_PING  = 4'b0100,
    PID_RSVD  = 4'b0000
  } pid_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_PID,
    RX_TOKEN,
    RX_EOPW,
    RX_DRAIN
  } rx_state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_PID  = 2'b01,
    ERR_CRC  = 2'b10,
    ERR_LEN  = 2'b11
  } err_t;

  localparam logic [4:0] CRC5_INIT    = 5'b11111;
  localparam logic [4:0] CRC5_POLY    = 5'b00101;
  localparam logic [4:0] CRC5_RESIDUE = 5'b01100;

  // One serial step of x^5+x^2+1.
  function automatic logic [4:0] crc5_next(input logic [4:0] crc, input logic b);
    logic fb;
    fb = crc[4] ^ b;
    return {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
  endfunction

  function automatic logic is_token_pid(input logic [3:0] p);
    return (p == PID_OUT) || (p == PID_IN) || (p == PID_SOF) || (p == PID_SETUP);
  endfunction

endpackage

// File: rtl/usb_crc5_serial.sv
// Serial CRC5 register; init has priority over en. Shared by the token
// receive framer and the transmit token generator.
module usb_crc5_serial
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       init,
  input  logic       en,
  input  logic       bit_in,
  output logic [4:0] crc
);

  logic [4:0] crc_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc_q <= CRC5_INIT;
    end else if (init) begin
      crc_q <= CRC5_INIT;
    end else if (en) begin
      crc_q <= crc5_next(crc_q, bit_in);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_token_rx.sv
// Token packet framer: SYNC hunt, PID check, 16-bit token capture with
// in-line CRC5, and one registered result per token-class packet.
//
// state    | meaning
// RX_IDLE  | counting SYNC zeros, waiting for the terminating 1
// RX_PID   | shifting the 8 PID bits
// RX_TOKEN | shifting 11 data + 5 CRC bits
// RX_EOPW  | all 16 bits in, waiting for EOP
// RX_DRAIN | ignoring bits until EOP, then reporting any pending error
module usb_token_rx
  import usb_pkg::*;
#(
  parameter int unsigned SYNC_MIN_ZEROS = 6
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        rx_bit,
  input  logic        rx_bit_en,
  input  logic        rx_eop,
  output logic [3:0]  tok_pid,
  output logic [10:0] tok_data,
  output logic [6:0]  tok_addr,
  output logic [3:0]  tok_endp,
  output logic        tok_strobe,
  output logic        tok_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam logic [3:0] SYNC_MIN = 4'(SYNC_MIN_ZEROS);

  rx_state_t   state_q, state_b;
  err_t        pend_q, pend_b;
  logic [3:0]  zero_cnt_q, zero_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  pid_sh_q, pid_sh_d;
  logic [15:0] tok_sh_q, tok_sh_d;
  logic [7:0]  pid_nxt;
  logic [4:0]  crc, crc_eff;
  logic        crc_init, crc_en;

  logic [3:0]  tok_pid_q;
  logic [10:0] tok_data_q;
  logic        tok_strobe_q, tok_err_q;
  logic [1:0]  err_code_q;

  usb_crc5_serial u_crc (
    .clk    (clk),
    .n_rst  (n_rst),
    .init   (crc_init),
    .en     (crc_en),
    .bit_in (rx_bit),
    .crc    (crc)
  );

  // Bit step: state_b is where the FSM lands after this cycle's bit, before
  // any same-cycle EOP is applied.
  always_comb begin
    state_b    = state_q;
    pend_b     = pend_q;
    zero_cnt_d = zero_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    pid_sh_d   = pid_sh_q;
    tok_sh_d   = tok_sh_q;
    crc_init   = 1'b0;
    crc_en     = 1'b0;
    pid_nxt    = {rx_bit, pid_sh_q[7:1]};

    if (rx_bit_en) begin
      case (state_q)
        RX_IDLE: begin
          if (!rx_bit) begin
            zero_cnt_d = (zero_cnt_q == 4'hF) ? 4'hF : zero_cnt_q + 4'd1;
          end else begin
            zero_cnt_d = 4'd0;
            if (zero_cnt_q >= SYNC_MIN) begin
              state_b   = RX_PID;
              bit_cnt_d = 4'd0;
              pend_b    = ERR_NONE;
            end
          end
        end
        RX_PID: begin
          pid_sh_d  = pid_nxt;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            if (pid_nxt[7:4] != ~pid_nxt[3:0]) begin
              state_b = RX_DRAIN;
              pend_b  = ERR_PID;
            end else if (is_token_pid(pid_nxt[3:0])) begin
              state_b  = RX_TOKEN;
              crc_init = 1'b1;
            end else begin
              state_b = RX_DRAIN;
              pend_b  = ERR_NONE;
            end
          end
        end
        RX_TOKEN: begin
          tok_sh_d  = {rx_bit, tok_sh_q[15:1]};
          crc_en    = 1'b1;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            state_b = RX_EOPW;
          end
        end
        RX_EOPW: begin
          state_b = RX_DRAIN;
          pend_b  = ERR_LEN;
        end
        RX_DRAIN: begin
        end
        default: begin
          state_b = RX_IDLE;
        end
      endcase
    end

    // Residue must include a 16th bit arriving together with EOP.
    crc_eff = (rx_bit_en && (state_q == RX_TOKEN)) ? crc5_next(crc, rx_bit) : crc;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= RX_IDLE;
      pend_q       <= ERR_NONE;
      zero_cnt_q   <= 4'd0;
      bit_cnt_q    <= 4'd0;
      pid_sh_q     <= 8'd0;
      tok_sh_q     <= 16'd0;
      tok_pid_q    <= 4'd0;
      tok_data_q   <= 11'd0;
      tok_strobe_q <= 1'b0;
      tok_err_q    <= 1'b0;
      err_code_q   <= 2'b00;
    end else begin
      state_q      <= state_b;
      pend_q       <= pend_b;
      zero_cnt_q   <= zero_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      pid_sh_q     <= pid_sh_d;
      tok_sh_q     <= tok_sh_d;
      tok_strobe_q <= 1'b0;
      tok_err_q    <= 1'b0;

      if (rx_eop) begin
        case (state_b)
          RX_IDLE: begin
          end
          RX_PID: begin
            state_q <= RX_IDLE;
          end
          RX_TOKEN: begin
            state_q    <= RX_IDLE;
            tok_err_q  <= 1'b1;
            err_code_q <= ERR_LEN;
          end
          RX_EOPW: begin
            state_q <= RX_IDLE;
            if (crc_eff == CRC5_RESIDUE) begin
              tok_strobe_q <= 1'b1;
              err_code_q   <= ERR_NONE;
              tok_pid_q    <= pid_sh_d[3:0];
              tok_data_q   <= tok_sh_d[10:0];
            end else begin
              tok_err_q  <= 1'b1;
              err_code_q <= ERR_CRC;
            end
          end
          RX_DRAIN: begin
            state_q <= RX_IDLE;
            if (pend_b != ERR_NONE) begin
              tok_err_q  <= 1'b1;
              err_code_q <= pend_b;
            end
          end
          default: begin
            state_q <= RX_IDLE;
          end
        endcase
      end
    end
  end

  assign tok_pid    = tok_pid_q;
  assign tok_data   = tok_data_q;
  assign tok_addr   = tok_data_q[6:0];
  assign tok_endp   = tok_data_q[10:7];
  assign tok_strobe = tok_strobe_q;
  assign tok_err    = tok_err_q;
  assign err_code   = err_code_q;
  assign busy       = (state_q != RX_IDLE);

endmodule
